// File: rtl/blackjack_pkg.sv
// Shared deck definitions for the blackjack card path: deck geometry,
// the card index type, dealer FSM states and rank/suit decode helpers.
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int SUIT_SIZE = 13;

  typedef logic [5:0] card_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    SCAN = 2'd2
  } dealer_state_t;

  localparam card_t SUIT1_BASE = card_t'(SUIT_SIZE);
  localparam card_t SUIT2_BASE = card_t'(2 * SUIT_SIZE);
  localparam card_t SUIT3_BASE = card_t'(3 * SUIT_SIZE);

  // Suit = card / 13, resolved with three magnitude compares instead of a divider.
  function automatic logic [1:0] card_suit(input card_t c);
    logic [1:0] s;
    if (c >= SUIT3_BASE) begin
      s = 2'd3;
    end else if (c >= SUIT2_BASE) begin
      s = 2'd2;
    end else if (c >= SUIT1_BASE) begin
      s = 2'd1;
    end else begin
      s = 2'd0;
    end
    return s;
  endfunction

  // Rank = card - 13*suit + 1 (Ace = 1 .. King = 13), via compare/subtract.
  function automatic logic [3:0] card_rank(input card_t c);
    card_t base;
    if (c >= SUIT3_BASE) begin
      base = c - SUIT3_BASE;
    end else if (c >= SUIT2_BASE) begin
      base = c - SUIT2_BASE;
    end else if (c >= SUIT1_BASE) begin
      base = c - SUIT1_BASE;
    end else begin
      base = c;
    end
    return base[3:0] + 4'd1;
  endfunction

endpackage

// File: rtl/card_dealer.sv
// Draws cards without replacement from one 52-card deck. Random picks are
// tried first; after MAX_TRIES rejections a linear scan from the last random
// position guarantees the draw completes. All outputs are registered.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int MAX_TRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] randnum,
  input  logic        draw_req,
  input  logic        shuffle,
  output logic        card_valid,
  output logic [5:0]  card,
  output logic [3:0]  rank,
  output logic [1:0]  suit,
  output logic        busy,
  output logic        empty_err,
  output logic [5:0]  cards_left
);

  localparam card_t       LAST_CARD = card_t'(DECK_SIZE - 1);
  localparam card_t       FULL_DECK = card_t'(DECK_SIZE);
  localparam logic [5:0]  TRY_LIMIT = 6'(MAX_TRIES);

  dealer_state_t state_q, state_d;
  logic [51:0]   used_q, used_d;
  logic [5:0]    left_q, left_d;
  logic [5:0]    tries_q, tries_d;
  card_t         idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          empty_q, empty_d;
  logic          busy_q, busy_d;
  card_t         card_q, card_d;
  logic [3:0]    rank_q, rank_d;
  logic [1:0]    suit_q, suit_d;

  // Only the low six bits of the random word carry entropy for us.
  logic          unused_rand_hi;
  assign unused_rand_hi = ^randnum[31:6];

  card_t       pick_c;
  logic [63:0] used_ext;
  logic        pick_ok;
  logic        scan_ok;
  logic [5:0]  tries_inc;
  logic        tries_done;
  card_t       wrap_c;

  assign pick_c     = randnum[5:0];
  assign used_ext   = {12'd0, used_q};
  assign pick_ok    = (pick_c < FULL_DECK) && !used_ext[pick_c];
  assign scan_ok    = !used_ext[idx_q];
  assign tries_inc  = tries_q + 6'd1;
  assign tries_done = (tries_inc == TRY_LIMIT);
  assign wrap_c     = (pick_c < FULL_DECK) ? pick_c : (pick_c - FULL_DECK);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: shuffle always wins, otherwise advance the draw.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (shuffle) begin
          state_d = IDLE;
        end else if (draw_req && (left_q != 6'd0)) begin
          state_d = PICK;
        end else begin
          state_d = IDLE;
        end
      end
      PICK: begin
        if (shuffle || pick_ok) begin
          state_d = IDLE;
        end else if (tries_done) begin
          state_d = SCAN;
        end else begin
          state_d = PICK;
        end
      end
      SCAN: begin
        if (shuffle || scan_ok) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values: deck mask, counters and the dealt card.
  always_comb begin
    logic  take;
    card_t take_card;
    take      = 1'b0;
    take_card = pick_c;
    used_d    = used_q;
    left_d    = left_q;
    tries_d   = tries_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    empty_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    card_d    = card_q;
    rank_d    = rank_q;
    suit_d    = suit_q;
    case (state_q)
      IDLE: begin
        if (shuffle) begin
          used_d = 52'd0;
          left_d = FULL_DECK;
        end else if (draw_req) begin
          if (left_q == 6'd0) begin
            empty_d = 1'b1;
          end else begin
            tries_d = 6'd0;
          end
        end else begin
          tries_d = tries_q;
        end
      end
      PICK: begin
        if (shuffle) begin
          used_d = 52'd0;
          left_d = FULL_DECK;
        end else if (pick_ok) begin
          take      = 1'b1;
          take_card = pick_c;
        end else begin
          tries_d = tries_inc;
          if (tries_done) begin
            idx_d = wrap_c;
          end else begin
            idx_d = idx_q;
          end
        end
      end
      SCAN: begin
        if (shuffle) begin
          used_d = 52'd0;
          left_d = FULL_DECK;
        end else if (scan_ok) begin
          take      = 1'b1;
          take_card = idx_q;
        end else begin
          idx_d = (idx_q == LAST_CARD) ? 6'd0 : (idx_q + 6'd1);
        end
      end
      default: begin
        used_d = used_q;
      end
    endcase
    if (take) begin
      used_d[take_card] = 1'b1;
      left_d  = left_q - 6'd1;
      valid_d = 1'b1;
      card_d  = take_card;
      rank_d  = card_rank(take_card);
      suit_d  = card_suit(take_card);
    end else begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used_q  <= 52'd0;
      left_q  <= FULL_DECK;
      tries_q <= 6'd0;
      idx_q   <= 6'd0;
      valid_q <= 1'b0;
      empty_q <= 1'b0;
      busy_q  <= 1'b0;
      card_q  <= 6'd0;
      rank_q  <= 4'd1;
      suit_q  <= 2'd0;
    end else begin
      used_q  <= used_d;
      left_q  <= left_d;
      tries_q <= tries_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      busy_q  <= busy_d;
      card_q  <= card_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
    end
  end

  assign card_valid = valid_q;
  assign card       = card_q;
  assign rank       = rank_q;
  assign suit       = suit_q;
  assign busy       = busy_q;
  assign empty_err  = empty_q;
  assign cards_left = left_q;

endmodule
